// File: rtl/instr_mem_loader.sv
// Instruction memory with byte-stream loader; serves the program counter once loading is done.
// Fetch is combinational (0-cycle); loader writes a word on the edge accepting its last byte.
// ld_ready is high only while loading; the core is held in reset (core_rst_n=0) until then.
module instr_mem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_rst_n,
  input  logic [31:0] pc_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] wr_ptr_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   asm_q;
  logic          core_rst_n_q;
  logic          fetch_fault_q;
  logic [31:0]   fault_addr_q;

  logic          ld_accept;
  logic          word_wr;
  logic          last_slot;
  logic [31:0]   word_d;
  logic          fetch_legal;
  logic [AW-1:0] pc_idx;

  // Bytes are only taken while loading; a write happens on the 4th byte or on ld_last.
  assign ld_accept = ld_valid && (state_q == ST_LOAD);
  assign word_wr   = ld_accept && ((byte_idx_q == 2'd3) || ld_last);
  assign last_slot = (wr_ptr_q == AW'(DEPTH_WORDS - 1));

  // Aligned and inside the array; upper address bits must all be zero, so no wrap-around.
  assign fetch_legal = (pc_addr[1:0] == 2'b00) && (pc_addr[31:AW+2] == '0);
  assign pc_idx      = pc_addr[AW+1:2];

  // Merge the incoming byte into its lane; lanes above it are still zero from the last clear.
  always_comb begin
    word_d = asm_q;
    word_d[{byte_idx_q, 3'b000} +: 8] = ld_byte;
  end

  // Combinational fetch port; anything not a legal RUN fetch reads as NOP.
  always_comb begin
    instr_valid = (state_q == ST_RUN) && fetch_legal;
    instr_out   = instr_valid ? mem_q[pc_idx] : NOP_WORD;
  end

  assign ld_ready    = (state_q == ST_LOAD);
  assign core_rst_n  = core_rst_n_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_addr  = fault_addr_q;

  // Storage array: cleared to NOP on reset, written only by the loader.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (word_wr) begin
      mem_q[wr_ptr_q] <= word_d;
    end
  end

  // Control FSM: LOAD assembles words, RUN watches fetches, FAULT is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      byte_idx_q    <= 2'd0;
      asm_q         <= 32'd0;
      core_rst_n_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_accept) begin
            if (word_wr) begin
              asm_q      <= 32'd0;
              byte_idx_q <= 2'd0;
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              // Program end or array full: release the core from the next cycle on.
              if (ld_last || last_slot) begin
                state_q      <= ST_RUN;
                core_rst_n_q <= 1'b1;
              end
            end else begin
              asm_q      <= word_d;
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (!fetch_legal) begin
            state_q       <= ST_FAULT;
            fault_addr_q  <= pc_addr;
            fetch_fault_q <= 1'b1;
            core_rst_n_q  <= 1'b0;
          end
        end
        ST_FAULT: begin
          // Only reset leaves this state.
        end
        default: begin
          state_q       <= ST_FAULT;
          fetch_fault_q <= 1'b1;
          core_rst_n_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed cases plus randomized load/fetch trials.
// Reference model keeps the loaded byte stream and derives words and legality from it.
// Two instances: default depth and a 4-word array for the array-full case.
module tb_instr_mem_loader;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid, ld_last, ld_ready, core_rst_n;
  logic [7:0]  ld_byte;
  logic [31:0] pc_addr, instr_out, fault_addr;
  logic        instr_valid, fetch_fault;

  logic        ld_valid4, ld_last4, ld_ready4, core_rst_n4;
  logic [7:0]  ld_byte4;
  logic [31:0] pc_addr4, instr_out4, fault_addr4;
  logic        instr_valid4, fetch_fault4;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog[$];
  bit         model_loading;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .core_rst_n(core_rst_n), .pc_addr(pc_addr), .instr_out(instr_out),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault), .fault_addr(fault_addr)
  );

  instr_mem_loader #(.DEPTH_WORDS(4), .NOP_WORD(NOP)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid4), .ld_byte(ld_byte4), .ld_last(ld_last4), .ld_ready(ld_ready4),
    .core_rst_n(core_rst_n4), .pc_addr(pc_addr4), .instr_out(instr_out4),
    .instr_valid(instr_valid4), .fetch_fault(fetch_fault4), .fault_addr(fault_addr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Word idx of the program as loaded into a depth-word array.
  function automatic logic [31:0] model_word(input int idx, input int depth);
    int          len;
    logic [31:0] w;
    len = prog.size();
    if (len > depth * 4) len = depth * 4;
    if (idx >= depth || idx * 4 >= len) return NOP;
    w = 32'd0;
    for (int j = 0; j < 4; j++)
      if (idx * 4 + j < len) w[8*j +: 8] = prog[idx*4 + j];
    return w;
  endfunction

  function automatic bit model_legal(input logic [31:0] a, input int depth);
    return (a % 4 == 0) && ({32'd0, a} < 64'(4 * depth));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ld_ready"},    32'(ld_ready),    32'd1);
    chk({tag, ".core_rst_n"},  32'(core_rst_n),  32'd0);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".instr_out"},   instr_out,        NOP);
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, ".fault_addr"},  fault_addr,       32'd0);
  endtask

  task automatic do_reset();
    ld_valid = 0; ld_last = 0; ld_byte = 0; pc_addr = 0;
    ld_valid4 = 0; ld_last4 = 0; ld_byte4 = 0; pc_addr4 = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    prog.delete();
    model_loading = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1; ld_byte = b; ld_last = last;
    @(posedge clk);
    #1;
    ld_valid = 0; ld_last = 0;
    if (model_loading) begin
      prog.push_back(b);
      if (last || prog.size() == DEPTH * 4) model_loading = 0;
    end
  endtask

  task automatic idle_cycle();
    ld_valid = 0; ld_last = 1'($urandom);
    @(posedge clk);
    #1 ld_last = 0;
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] a);
    pc_addr = a;
    #1;
    chk({tag, ".valid"}, 32'(instr_valid), 32'(model_legal(a, DEPTH)));
    chk({tag, ".instr"}, instr_out, model_legal(a, DEPTH) ? model_word(int'(a / 4), DEPTH) : NOP);
    @(posedge clk);
    #1;
  endtask

  task automatic fault_check(input string tag, input logic [31:0] a);
    pc_addr = a;
    #1;
    chk({tag, ".bad_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".bad_instr"}, instr_out, NOP);
    chk({tag, ".still_run"}, 32'(core_rst_n), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, ".fault"},      32'(fetch_fault), 32'd1);
    chk({tag, ".fault_addr"}, fault_addr, a);
    chk({tag, ".core_hold"},  32'(core_rst_n), 32'd0);
    pc_addr = 32'd0;
    #1;
    chk({tag, ".post_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".post_instr"}, instr_out, NOP);
    pc_addr = 32'h40;
    @(posedge clk);
    #1;
    chk({tag, ".addr_hold"}, fault_addr, a);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  p1 [8];
    logic [7:0]  p3 [6];
    logic [31:0] bad;
    int          n;
    p1 = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    p3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    // Reset state
    ld_valid = 0; ld_last = 0; ld_byte = 0; pc_addr = 0; reset_n = 0;
    ld_valid4 = 0; ld_last4 = 0; ld_byte4 = 0; pc_addr4 = 0;
    #3;
    check_reset_outputs("rst");
    do_reset();

    // Two-word program, then fetches
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t1.hold_before_last", 32'(core_rst_n), 32'd0);
      send_byte(p1[i], i == 7);
    end
    chk("t1.core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t1.ld_ready", 32'(ld_ready), 32'd0);
    fetch_check("t1.pc0", 32'd0);
    chk("t1.word0_const", model_word(0, DEPTH), 32'h0050_0513);
    fetch_check("t1.pc4", 32'd4);
    fetch_check("t1.pc8", 32'd8);
    pc_addr = 32'd0;
    #1 chk("t2.pc0_direct", instr_out, 32'h0050_0513);
    pc_addr = 32'd4;
    #1 chk("t2.pc4_direct", instr_out, 32'h0010_0593);
    // Misaligned fetch faults, then async reset clears everything
    fault_check("t4", 32'd2);
    #2 reset_n = 0;
    #1 check_reset_outputs("t4.async_rst");
    do_reset();

    // Partial last word
    for (int i = 0; i < 6; i++) send_byte(p3[i], i == 5);
    pc_addr = 32'd4;
    #1 chk("t3.word1", instr_out, 32'h0000_FFEE);
    chk("t3.run", 32'(core_rst_n), 32'd1);
    fetch_check("t3.pc0", 32'd0);
    fetch_check("t3.pc4", 32'd4);

    // Reset mid-load, then reload from word 0
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h11 * 8'(i + 1), 1'b0);
    #2 reset_n = 0;
    #1 check_reset_outputs("t6.midload");
    do_reset();
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 1);
    fetch_check("t6.pc0", 32'd0);
    chk("t6.word0_const", model_word(0, DEPTH), 32'h1234_5678);
    fetch_check("t6.pc4", 32'd4);

    // 4-word array fills without ld_last; extra bytes ignored
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("t5.ready%0d", k), 32'(ld_ready4), 32'(k <= 16));
      ld_valid4 = 1; ld_byte4 = 8'(k); ld_last4 = 0;
      @(posedge clk);
      #1 ld_valid4 = 0;
      if (k == 16) chk("t5.core_rst_n", 32'(core_rst_n4), 32'd1);
    end
    for (int w = 0; w < 4; w++) begin
      pc_addr4 = 32'(4 * w);
      #1;
      chk($sformatf("t5.word%0d", w), instr_out4,
          {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
      chk($sformatf("t5.valid%0d", w), 32'(instr_valid4), 32'd1);
    end
    pc_addr4 = 32'h10;
    #1 chk("t5.oob_valid", 32'(instr_valid4), 32'd0);
    @(posedge clk);
    #1;
    chk("t5.fault", 32'(fetch_fault4), 32'd1);
    chk("t5.fault_addr", fault_addr4, 32'h10);
    chk("t5.core_hold", 32'(core_rst_n4), 32'd0);

    // Randomized programs with gaps and stray ld_last pulses
    for (int t = 0; t < 10; t++) begin
      do_reset();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) idle_cycle();
        send_byte(8'($urandom), i == n - 1);
      end
      chk($sformatf("r%0d.run", t), 32'(core_rst_n), 32'd1);
      chk($sformatf("r%0d.ready", t), 32'(ld_ready), 32'd0);
      send_byte(8'($urandom), 1'b1);
      for (int f = 0; f < 6; f++)
        fetch_check($sformatf("r%0d.f%0d", t, f), 32'(4 * $urandom_range(0, n / 4 + 2)));
      case ($urandom_range(0, 2))
        0:       bad = 32'(4 * $urandom_range(0, 20) + $urandom_range(1, 3));
        1:       bad = 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
        default: bad = $urandom | 32'h8000_0000;
      endcase
      fault_check($sformatf("r%0d.bad", t), bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
